// File: rtl/serial_shift_left_unit.sv
// Multi-cycle logical shift-left for the ALU: one bit per clock under a start/done handshake.
// Result and CF/ZF/SF hold after done until the next accepted start.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready=1; a start loads operand, carry and capped shift count
// S_SHIFT | shift one bit per edge, down-counting to terminal count 0
// S_DONE  | done=1 for one cycle, then back to S_IDLE
module serial_shift_left_unit #(
   parameter int WIDTH     = 6,
   parameter int MAX_SHIFT = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dataIn,
   input  logic [WIDTH-1:0] dataIn2,
   input  logic             CF_OLD,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] dataOut,
   output logic             CF,
   output logic             ZF,
   output logic             SF
);

   localparam int               CNT_W       = $clog2(MAX_SHIFT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_SHIFT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [WIDTH-1:0] MAX_SHIFT_W = WIDTH'(MAX_SHIFT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic               cf_q, cf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   amt_cap;

   // Amounts beyond the cap behave identically: the extra shifts only move out zeros.
   assign amt_cap = (dataIn2 > MAX_SHIFT_W) ? CNT_MAX : dataIn2[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         cf_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cf_q    <= cf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cf_d    = cf_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sh_d    = dataIn;
               cf_d    = CF_OLD;
               cnt_d   = amt_cap;
               state_d = (amt_cap != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            cf_d  = sh_q[WIDTH-1];
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ready   = (state_q == S_IDLE);
   assign done    = (state_q == S_DONE);
   assign dataOut = sh_q;
   assign CF      = cf_q;
   assign ZF      = (sh_q == '0);
   assign SF      = sh_q[WIDTH-1];

endmodule

// File: tb/tb_serial_shift_left_unit.sv
// Bench for serial_shift_left_unit: directed and randomized operations checked against
// an arithmetic model of the shift result, carry and latency.
module tb_serial_shift_left_unit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] dataIn;
   logic [5:0] dataIn2;
   logic       CF_OLD;
   logic       ready;
   logic       done;
   logic [5:0] dataOut;
   logic       CF;
   logic       ZF;
   logic       SF;

   int pass_cnt  = 0;
   int total_cnt = 0;

   serial_shift_left_unit #(.WIDTH(6), .MAX_SHIFT(7)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .dataIn  (dataIn),
      .dataIn2 (dataIn2),
      .CF_OLD  (CF_OLD),
      .ready   (ready),
      .done    (done),
      .dataOut (dataOut),
      .CF      (CF),
      .ZF      (ZF),
      .SF      (SF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] exp_out(input logic [5:0] din, input int amt);
      int v;
      if (amt >= 6) return 6'd0;
      v = int'(din) * (1 << amt);
      return 6'(v % 64);
   endfunction

   function automatic logic exp_cf(input logic [5:0] din, input int amt, input logic cfold);
      if (amt == 0) return cfold;
      if (amt <= 6) return din[6-amt];
      return 1'b0;
   endfunction

   function automatic int exp_lat(input int amt);
      return ((amt > 7) ? 7 : amt) + 1;
   endfunction

   // Called at a negedge while idle; returns at the negedge of the IDLE cycle after done.
   task automatic do_op(input logic [5:0] din, input logic [5:0] amt, input logic cfold,
                        input bit hold, input string name);
      logic [5:0] e_out;
      logic       e_cf;
      int         e_lat;
      int         k;
      bit         got;
      e_out = exp_out(din, int'(amt));
      e_cf  = exp_cf(din, int'(amt), cfold);
      e_lat = exp_lat(int'(amt));
      total_cnt++;
      if (ready !== 1'b1) $display("FAIL %s ready_before_start got=%b want=1", name, ready);
      else pass_cnt++;
      dataIn  = din;
      dataIn2 = amt;
      CF_OLD  = cfold;
      start   = 1'b1;
      @(posedge clk);
      k   = 0;
      got = 0;
      while (k < 20 && !got) begin
         @(negedge clk);
         k++;
         if (!hold) start = 1'b0;
         if (done === 1'b1) got = 1;
         else begin
            dataIn  = 6'($urandom);
            dataIn2 = 6'($urandom);
            CF_OLD  = 1'($urandom);
         end
      end
      total_cnt++;
      if (!got) $display("FAIL %s done_timeout got=none want=cycle %0d", name, e_lat);
      else pass_cnt++;
      total_cnt++;
      if (k !== e_lat) $display("FAIL %s latency got=%0d want=%0d", name, k, e_lat);
      else pass_cnt++;
      total_cnt++;
      if (dataOut !== e_out) $display("FAIL %s dataOut got=%b want=%b", name, dataOut, e_out);
      else pass_cnt++;
      total_cnt++;
      if (CF !== e_cf) $display("FAIL %s CF got=%b want=%b", name, CF, e_cf);
      else pass_cnt++;
      total_cnt++;
      if (ZF !== (e_out == 6'd0)) $display("FAIL %s ZF got=%b want=%b", name, ZF, (e_out == 6'd0));
      else pass_cnt++;
      total_cnt++;
      if (SF !== e_out[5]) $display("FAIL %s SF got=%b want=%b", name, SF, e_out[5]);
      else pass_cnt++;
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL %s ready_at_done got=%b want=0", name, ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || ready !== 1'b1)
         $display("FAIL %s after_done done=%b ready=%b want done=0 ready=1", name, done, ready);
      else pass_cnt++;
      total_cnt++;
      if (dataOut !== e_out || CF !== e_cf)
         $display("FAIL %s hold dataOut=%b CF=%b want %b %b", name, dataOut, CF, e_out, e_cf);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      start   = 1'b0;
      dataIn  = 6'd0;
      dataIn2 = 6'd0;
      CF_OLD  = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (ready !== 1'b1 || done !== 1'b0)
         $display("FAIL reset_hs ready=%b done=%b want 1 0", ready, done);
      else pass_cnt++;
      total_cnt++;
      if (dataOut !== 6'd0 || CF !== 1'b0 || ZF !== 1'b1 || SF !== 1'b0)
         $display("FAIL reset_out dataOut=%b CF=%b ZF=%b SF=%b want 000000 0 1 0",
                  dataOut, CF, ZF, SF);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      do_op(6'b000101, 6'd2,  1'b0, 0, "dir_shl2");
      do_op(6'b110000, 6'd1,  1'b0, 0, "dir_shl1");
      do_op(6'b101010, 6'd0,  1'b1, 0, "dir_shl0");
      do_op(6'b000001, 6'd6,  1'b0, 0, "dir_shl6");
      do_op(6'b111111, 6'd63, 1'b1, 0, "dir_shl63");
      do_op(6'b111111, 6'd7,  1'b1, 0, "dir_shl7");
      do_op(6'b100001, 6'd8,  1'b1, 0, "dir_shl8");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [5:0] a;
         a = (i % 3 == 0) ? 6'($urandom) : 6'($urandom_range(0, 8));
         do_op(6'($urandom), a, 1'($urandom), 0, "rand");
      end
   endtask

   task automatic test_ignore_busy();
      int  k;
      bit  got;
      dataIn  = 6'b000111;
      dataIn2 = 6'd5;
      CF_OLD  = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL ign_ready1 got=%b want=0", ready);
      else pass_cnt++;
      @(negedge clk);
      start   = 1'b1;
      dataIn  = 6'b111111;
      dataIn2 = 6'd0;
      CF_OLD  = 1'b1;
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL ign_ready2 got=%b want=0", ready);
      else pass_cnt++;
      @(negedge clk);
      start = 1'b0;
      k   = 3;
      got = (done === 1'b1);
      while (k < 20 && !got) begin
         @(negedge clk);
         k++;
         if (done === 1'b1) got = 1;
      end
      total_cnt++;
      if (!got || k !== 6) $display("FAIL ign_latency got=%0d want=6", k);
      else pass_cnt++;
      total_cnt++;
      if (dataOut !== 6'b100000 || CF !== 1'b1)
         $display("FAIL ign_result dataOut=%b CF=%b want 100000 1", dataOut, CF);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (ready !== 1'b1 || dataOut !== 6'b100000)
         $display("FAIL ign_idle ready=%b dataOut=%b want 1 100000", ready, dataOut);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         do_op(6'($urandom), 6'($urandom_range(0, 9)), 1'($urandom), 1, "b2b");
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int done_seen;
      dataIn  = 6'b101101;
      dataIn2 = 6'd5;
      CF_OLD  = 1'b1;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (dataOut !== 6'd0 || CF !== 1'b0 || ZF !== 1'b1 || SF !== 1'b0)
         $display("FAIL rstmid_out dataOut=%b CF=%b ZF=%b SF=%b want 000000 0 1 0",
                  dataOut, CF, ZF, SF);
      else pass_cnt++;
      total_cnt++;
      if (ready !== 1'b1 || done !== 1'b0)
         $display("FAIL rstmid_hs ready=%b done=%b want 1 0", ready, done);
      else pass_cnt++;
      done_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      total_cnt++;
      if (done_seen !== 0) $display("FAIL rstmid_nodone got=%0d pulses want=0", done_seen);
      else pass_cnt++;
      do_op(6'b010011, 6'd3, 1'b0, 0, "rstmid_fresh");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
